// File: rtl/rv32_types.sv
// rtl/rv32_types.sv - shared fetch types: FSM state enum and fetch buffer entry
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

package rv32_types;

    localparam int XLEN = `XPR_LEN;

    // Fetch address advance per granted request
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// rtl/rv32_fetch_fifo.sv - instruction buffer with push/pop/flush and full/empty flags
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module rv32_fetch_fifo
    import rv32_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t wdata_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t rdata_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         almost_full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // A push into a full buffer is legal only when the head leaves in the same cycle
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != DEPTH_C) || do_pop);

    assign rdata_o       = mem_q[rptr_q];
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == DEPTH_C);
    assign almost_full_o = (count_q == (DEPTH_C - CW'(1)));

    // Pointer and occupancy update; flush wins over any push or pop
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed while the buffer is non-empty
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rv32_instr_fetch.sv
// rtl/rv32_instr_fetch.sv - RV32 instruction fetch unit; optional stall counter via RV32_FETCH_STALL_CNT_EN
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module rv32_instr_fetch
    import rv32_types::*;
#(
    parameter logic [`XPR_LEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [`XPR_LEN-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [`XPR_LEN-1:0] imem_rdata,
    input  logic                redirect_valid,
    input  logic [`XPR_LEN-1:0] redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [`XPR_LEN-1:0] out_instr,
    output logic [`XPR_LEN-1:0] out_pc
`ifdef RV32_FETCH_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    fetch_state_e        state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [XLEN-1:0]     req_pc_q, req_pc_d;
    logic                run_q;
    logic                grant;
    logic                push;
    logic                pop_fire;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_afull;
    fetch_entry_t        push_entry;
    fetch_entry_t        head_entry;

    // Buffer occupancy plus the single outstanding response never exceeds the depth:
    // a request is only issued from REQ, which is entered only when a slot is free.
    rv32_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .wdata_i      (push_entry),
        .pop_i        (pop_fire),
        .flush_i      (redirect_valid),
        .rdata_o      (head_entry),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .almost_full_o(fifo_afull)
    );

    // run_q holds off the first request until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= REQ;
        else        state_q <= state_d;
    end

    // FSM next-state; a redirect leaves exactly one response to discard when one is in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (redirect_valid || pop_fire || !fifo_full) state_d = REQ;
            end
            REQ: begin
                if (grant) state_d = redirect_valid ? DROP : WAIT;
            end
            WAIT: begin
                if (redirect_valid)   state_d = imem_rvalid ? REQ : DROP;
                else if (imem_rvalid) state_d = (fifo_afull && !pop_fire) ? IDLE : REQ;
            end
            DROP: begin
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase
    end

    // FSM outputs and buffer handshakes; redirect kills any same-cycle push or pop
    always_comb begin
        imem_req   = run_q && (state_q == REQ);
        grant      = imem_req && imem_gnt;
        push       = (state_q == WAIT) && imem_rvalid && !redirect_valid;
        pop_fire   = !fifo_empty && out_ready && !redirect_valid;
        push_entry = '{instr: imem_rdata, pc: req_pc_q};
    end

    // Fetch PC and in-flight request PC next-state
    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (grant)          req_pc_d = pc_q;
        if (redirect_valid) pc_d     = redirect_pc;
        else if (grant)     pc_d     = pc_q + PC_STEP;
    end

    // Fetch PC and in-flight request PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = !fifo_empty;
    assign out_instr = fifo_empty ? '0 : head_entry.instr;
    assign out_pc    = fifo_empty ? '0 : head_entry.pc;

`ifdef RV32_FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles where decode is ready but has nothing to take
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else if (out_ready && !out_valid && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/rv32_instr_fetch.md
RV32_INSTR_FETCH -- requirements
Module: rv32_instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries, legal values 2 or 4.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port imem_req, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_addr, output, `XPR_LEN bits: fetch byte address.
REQ-007 SHALL have port imem_gnt, input, 1 bit: request accepted this cycle.
REQ-008 SHALL have port imem_rvalid, input, 1 bit: read data valid.
REQ-009 SHALL have port imem_rdata, input, `XPR_LEN bits: fetched instruction word.
REQ-010 SHALL have port redirect_valid, input, 1 bit: branch/jump/trap redirect.
REQ-011 SHALL have port redirect_pc, input, `XPR_LEN bits: redirect target.
REQ-012 SHALL have port out_valid, output, 1 bit: instruction available to decode/immediate stage.
REQ-013 SHALL have port out_ready, input, 1 bit: decode accepts.
REQ-014 SHALL have port out_instr, output, `XPR_LEN bits: instruction; feeds the immediate generator rv_instr.
REQ-015 SHALL have port out_pc, output, `XPR_LEN bits: PC of out_instr.

Function
REQ-016 SHALL keep at most one memory request outstanding (granted, response not yet received).
REQ-017 SHALL use FSM states IDLE, REQ, WAIT, DROP: REQ drives imem_req=1; REQ->WAIT on imem_gnt; WAIT->REQ (or IDLE if buffer has no free slot) on imem_rvalid; IDLE->REQ when a slot frees.
REQ-018 SHALL issue a request only when buffer entries plus outstanding responses < FIFO_DEPTH.
REQ-019 SHALL hold imem_addr and imem_req stable while in REQ until imem_gnt.
REQ-020 SHALL increment the fetch PC by 4 on each grant, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-021 SHALL push {imem_rdata, request PC} into the FIFO on imem_rvalid, except in DROP.
REQ-022 SHALL drive out_valid = FIFO non-empty, with out_instr/out_pc taken from the FIFO head; pop when out_valid && out_ready.
REQ-023 SHALL keep out_instr/out_pc stable while out_valid && !out_ready.
REQ-024 SHALL, on redirect_valid, flush the FIFO and drive out_valid=0 in the next cycle; set the fetch PC to redirect_pc; REQ restarts with the new address in the next cycle; WAIT->DROP.
REQ-025 SHALL, in DROP, discard the next imem_rvalid and then go to REQ at the redirect PC.
REQ-026 SHALL give redirect priority over a same-cycle pop, push or grant; a same-cycle grant still counts as outstanding and leads to DROP.
REQ-027 SHALL have latency: grant at cycle N, rvalid at cycle M, out_valid asserted at M+1 if the FIFO was empty.
REQ-028 SHALL, on simultaneous push and pop with the FIFO full, accept both without overflow.

Reset
REQ-029 SHALL reset asynchronously when rst_n=0: state REQ, fetch PC=RESET_PC, FIFO empty, out_valid=0, out_instr=0, out_pc=0, imem_req=0 during reset, imem_addr=RESET_PC.
REQ-030 SHALL assert imem_req on the first clk edge after rst_n deasserts; any in-flight response on memory is not tracked.

Configuration
REQ-031 SHALL, with RV32_FETCH_STALL_CNT_EN defined, add output stall_cnt, 32 bits: counts cycles with out_ready=1 && out_valid=0; reset to 0, saturating at 32'hFFFF_FFFF; cleared on redirect is NOT done.
REQ-032 SHALL, without RV32_FETCH_STALL_CNT_EN, omit the stall_cnt port and its logic entirely.

Structure
REQ-033 SHALL place the fetch FSM state enum and the typedef fetch_entry_t {instr, pc} in the shared rv32_types package.
REQ-034 SHALL implement the buffer as sub-module rv32_fetch_fifo (parameterized depth, push/pop/flush, full/empty).

Verification
REQ-035 SHALL cover reset fetch: RESET_PC=32'h100, gnt and rvalid always 1 -> out_pc sequence 0x100, 0x104, 0x108 with matching instructions.
REQ-036 SHALL cover backpressure: out_ready=0 for 10 cycles -> at most FIFO_DEPTH entries, no request beyond capacity, head held stable.
REQ-037 SHALL cover redirect while in WAIT: redirect to 0x2000 -> the stale rvalid is dropped and the next out_pc is 0x2000.
REQ-038 SHALL cover redirect with a same-cycle pop: FIFO holds 2 entries -> out_valid=0 next cycle and no stale PC ever appears.
REQ-039 SHALL cover wraparound: redirect to 0xFFFF_FFFC -> out_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-040 SHALL cover mid-operation reset: rst_n low during WAIT -> all outputs reach reset values immediately; fetching restarts at RESET_PC.
